fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 5-stage MIPS pipeline.
- Owns the architectural fetch PC and issues one instruction-memory request at a time through a req/gnt/rvalid handshake.
- Holds each fetched instruction in a one-entry buffer until the ID stage accepts it.
- Applies next-PC redirects from the ID-stage next-PC logic (jump, taken branch, jr), discarding any in-flight fetch that the redirect has made stale.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_ctrl_buf.sv | 30 +++
 rtl/fetch_ctrl.sv | 78 +++++++
 tb/tb_fetch_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, FSM state encodings and PC helpers for the fetch sequencer.
package fetch_ctrl_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int FETCH_STATE_WIDTH = 2;
    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;
    function automatic word_t align_word(input word_t a);
        return {a[WORD_WIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory handshake plus ID-stage buffer and redirect signals.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;
    logic  if_valid;
    word_t if_pc;
    word_t if_inst;
    logic  if_ready;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  align_err;
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst, align_err,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst, align_err,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: one-entry holding register for the instruction handed to ID.
module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  consume,
    input  logic  flush,
    input  word_t pc_in,
    input  word_t inst_in,
    output logic  valid,
    output word_t pc,
    output word_t inst
);
    // pc/inst are only written on load so they retain their value once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else begin
            valid <= load ? 1'b1 : (consume || flush) ? 1'b0 : valid;
            if (load) begin
                pc   <= pc_in;
                inst <= inst_in;
            end
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with redirect and stale-fetch kill.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter word_t RESET_PC = 32'hBFC0_0000,
    parameter word_t PC_STEP  = 32'd4
) (
    input logic clk,
    input logic rst_n,
    fetch_ctrl_if.master bus
);
    fetch_state_t state, state_nxt;
    word_t pc, pc_nxt, fetch_pc, target;
    logic kill, kill_nxt, align_q, redirect, load, consume, flush;

    assign target   = align_word(bus.redirect_pc);
    assign redirect = bus.redirect_valid && state != FETCH_IDLE;
    assign load     = state == FETCH_WAIT && bus.imem_rvalid && !kill && !bus.redirect_valid;
    assign consume  = state == FETCH_HOLD && bus.if_ready;
    assign flush    = state == FETCH_HOLD && bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH_IDLE: state_nxt = FETCH_REQ;
            FETCH_REQ:  state_nxt = bus.imem_gnt ? FETCH_WAIT : FETCH_REQ;
            FETCH_WAIT: state_nxt = !bus.imem_rvalid ? FETCH_WAIT :
                                    (kill || bus.redirect_valid) ? FETCH_REQ : FETCH_HOLD;
            FETCH_HOLD: state_nxt = (bus.if_ready || bus.redirect_valid) ? FETCH_REQ : FETCH_HOLD;
        endcase
    end

    always_comb begin
        bus.imem_req  = state == FETCH_REQ;
        bus.imem_addr = pc;
        bus.align_err = align_q;
    end

    // A redirect while a request is in flight marks its response stale
    always_comb begin
        pc_nxt   = redirect ? target : load ? pc + PC_STEP : pc;
        kill_nxt = kill;
        if (state == FETCH_REQ && bus.imem_gnt && bus.redirect_valid) kill_nxt = 1'b1;
        if (state == FETCH_WAIT) kill_nxt = bus.imem_rvalid ? 1'b0 : bus.redirect_valid ? 1'b1 : kill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            fetch_pc <= '0;
            kill     <= 1'b0;
            align_q  <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            kill     <= kill_nxt;
            align_q  <= redirect && bus.redirect_pc[1:0] != 2'b00;
            if (state == FETCH_REQ && bus.imem_gnt) fetch_pc <= pc;
        end
    end

    fetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .consume (consume),
        .flush   (flush),
        .pc_in   (fetch_pc),
        .inst_in (bus.imem_rdata),
        .valid   (bus.if_valid),
        .pc      (bus.if_pc),
        .inst    (bus.if_inst)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl driving memory and ID sides from the bench.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_req;
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        if (bus.imem_req !== 1'b1) check("req_timeout", {31'd0, bus.imem_req}, 32'd1);
    endtask

    // Grant at the current address, return data the next cycle; ends at a negedge in HOLD
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        wait_req;
        check("fetch_addr", bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        tick;
        bus.imem_gnt = 1'b0;
        check("wait_no_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = data;
        tick;
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic expect_buf(input logic [31:0] pc, input logic [31:0] inst);
        check("if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("if_pc", bus.if_pc, pc);
        check("if_inst", bus.if_inst, inst);
    endtask

    initial begin
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        tick;
        tick;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_align", {31'd0, bus.align_err}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'hBFC0_0000);
        rst_n = 1'b1;

        // Back-to-back sequential fetches with immediate consume
        fetch(32'hBFC0_0000, 32'h2408_0000);
        expect_buf(32'hBFC0_0000, 32'h2408_0000);
        bus.if_ready = 1'b1;
        tick;
        bus.if_ready = 1'b0;
        check("consumed_valid", {31'd0, bus.if_valid}, 32'd0);
        check("seq_addr", bus.imem_addr, 32'hBFC0_0004);

        // Stall in HOLD for 5 cycles
        fetch(32'hBFC0_0004, 32'h2408_0001);
        for (int i = 0; i < 5; i++) begin
            expect_buf(32'hBFC0_0004, 32'h2408_0001);
            check("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
            tick;
        end
        bus.if_ready = 1'b1;
        tick;
        bus.if_ready = 1'b0;
        check("after_stall_addr", bus.imem_addr, 32'hBFC0_0008);

        // Redirect in WAIT kills the in-flight fetch
        wait_req;
        check("wait_redir_addr", bus.imem_addr, 32'hBFC0_0008);
        bus.imem_gnt = 1'b1;
        tick;
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0100;
        tick;
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick;
        bus.imem_rvalid = 1'b0;
        check("killed_valid", {31'd0, bus.if_valid}, 32'd0);
        check("wait_redir_next", bus.imem_addr, 32'h0040_0100);

        // Redirect together with if_ready in HOLD delivers the delay slot
        fetch(32'h0040_0100, 32'h0000_0000);
        expect_buf(32'h0040_0100, 32'h0000_0000);
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0200;
        tick;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        check("hold_redir_valid", {31'd0, bus.if_valid}, 32'd0);
        check("hold_redir_addr", bus.imem_addr, 32'h0040_0200);

        // Redirect in the grant cycle: response discarded via kill
        bus.imem_gnt = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_1000;
        tick;
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b0;
        check("gnt_redir_no_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        tick;
        bus.imem_rvalid = 1'b0;
        check("gnt_redir_valid", {31'd0, bus.if_valid}, 32'd0);
        check("gnt_redir_addr", bus.imem_addr, 32'h0000_1000);

        // Misaligned redirect while ungranted in REQ
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0102;
        tick;
        bus.redirect_pc = 32'hFFFF_FFFC;
        check("mis_addr", bus.imem_addr, 32'h0040_0100);
        check("mis_align_hi", {31'd0, bus.align_err}, 32'd1);
        tick;
        bus.redirect_valid = 1'b0;
        check("mis_align_lo", {31'd0, bus.align_err}, 32'd0);

        // Wrap from the top of the address space
        fetch(32'hFFFF_FFFC, 32'h0BAD_F00D);
        expect_buf(32'hFFFF_FFFC, 32'h0BAD_F00D);
        bus.if_ready = 1'b1;
        tick;
        bus.if_ready = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Reset mid-transaction; the late response is ignored
        bus.imem_gnt = 1'b1;
        tick;
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        tick;
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check("midrst_addr", bus.imem_addr, 32'hBFC0_0000);
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick;
        bus.imem_rvalid = 1'b0;
        check("late_rvalid_valid", {31'd0, bus.if_valid}, 32'd0);
        check("late_rvalid_req", {31'd0, bus.imem_req}, 32'd1);
        check("late_rvalid_inst", bus.if_inst, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
